// File: rtl/ir_cmd_filter.sv
// ir_cmd_filter: turns validated NEC IR frames into ARM/DISARM/PANIC commands.
// Finds the new-frame edge, checks custom code and key, suppresses held-button
// repeats within a holdoff window, and offers one command over valid/ack.
//
// Ports:
//   iCLK         in   system clock
//   iRST         in   asynchronous active-high reset
//   iDATA_READY  in   frame-valid level from the IR receiver
//   iDATA[31:0]  in   frame: [15:0] custom code, [23:16] key, [31:24] ~key
//   iCMD_ACK     in   alarm controller accepts the pending command
//   oCMD_VALID   out  command pending, held until acknowledged
//   oCMD[1:0]    out  01 ARM, 10 DISARM, 11 PANIC, 00 when idle
//   oKEY[7:0]    out  raw key byte of the pending command
//   oOVERRUN     out  one-cycle pulse: frame dropped while a command pending
//   oERR_CNT     out  saturating count of rejected frames
//
// Build option:
//   IR_CUSTOM_CHECK_EN  defined: custom code must equal CUSTOM_CODE.
//                       undefined: any custom code passes.

module ir_cmd_filter #(
    parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
    parameter logic [7:0]  KEY_ARM     = 8'h12,
    parameter logic [7:0]  KEY_DISARM  = 8'h1A,
    parameter logic [7:0]  KEY_PANIC   = 8'h1E,
    parameter int unsigned HOLDOFF_CYC = 25000000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    input  logic        iCMD_ACK,
    output logic        oCMD_VALID,
    output logic [1:0]  oCMD,
    output logic [7:0]  oKEY,
    output logic        oOVERRUN,
    output logic [7:0]  oERR_CNT
);

    localparam int HW = $clog2(HOLDOFF_CYC);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYC - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Previous iDATA_READY; resets high so a level already present at
    // reset release is not mistaken for a fresh frame.
    logic rdy_prev_q;
    logic frame_ev;

    logic [7:0]    key_in_q, key_in_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [7:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic [7:0]    last_key_q, last_key_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    err_q, err_d;
    logic          ovr_q, ovr_d;

    logic       code_ok;
    logic [1:0] key_cmd;
    logic       key_ok;
    logic       reject;
    logic       suppress;
    logic       accept;
    logic       unused_bits;

    assign frame_ev = iDATA_READY & ~rdy_prev_q;

`ifdef IR_CUSTOM_CHECK_EN
    logic [15:0] code_q, code_d;

    always_comb begin
        code_d = code_q;
        if (state_q == S_IDLE && frame_ev) begin
            code_d = iDATA[15:0];
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            code_q <= '0;
        end else begin
            code_q <= code_d;
        end
    end

    assign code_ok     = (code_q == CUSTOM_CODE);
    assign unused_bits = ^iDATA[31:24];
`else
    assign code_ok     = 1'b1;
    assign unused_bits = ^{iDATA[31:24], iDATA[15:0], CUSTOM_CODE};
`endif

    // Key decode
    always_comb begin
        key_cmd = 2'b00;
        unique case (1'b1)
            (key_in_q == KEY_ARM):    key_cmd = 2'b01;
            (key_in_q == KEY_DISARM): key_cmd = 2'b10;
            (key_in_q == KEY_PANIC):  key_cmd = 2'b11;
            default:                  key_cmd = 2'b00;
        endcase
    end

    assign key_ok   = (key_cmd != 2'b00);
    assign reject   = ~code_ok | ~key_ok;
    // Only a repeat of the last issued key inside the window is dropped;
    // a different key always goes through.
    assign suppress = ~reject
                    & (key_in_q == last_key_q)
                    & (hold_q != '0);
    assign accept   = ~reject & ~suppress;

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (frame_ev) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = accept ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                if (iCMD_ACK) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        key_in_d   = key_in_q;
        cmd_d      = cmd_q;
        key_d      = key_q;
        valid_d    = valid_q;
        last_key_d = last_key_q;
        err_d      = err_q;
        ovr_d      = 1'b0;
        hold_d     = (hold_q != '0) ? hold_q - HOLD_ONE : hold_q;

        unique case (state_q)
            S_IDLE: begin
                if (frame_ev) begin
                    key_in_d = iDATA[23:16];
                end
            end
            S_CHECK: begin
                if (reject) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end else if (suppress) begin
                    // Held button keeps pushing the window out.
                    hold_d = HOLD_LOAD;
                end else begin
                    valid_d    = 1'b1;
                    cmd_d      = key_cmd;
                    key_d      = key_in_q;
                    last_key_d = key_in_q;
                    hold_d     = HOLD_LOAD;
                end
            end
            S_ISSUE: begin
                // A frame arriving now is dropped, even alongside the ack.
                ovr_d = frame_ev;
                if (iCMD_ACK) begin
                    valid_d = 1'b0;
                    cmd_d   = 2'b00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rdy_prev_q <= 1'b1;
            key_in_q   <= '0;
            cmd_q      <= '0;
            key_q      <= '0;
            valid_q    <= 1'b0;
            last_key_q <= '0;
            hold_q     <= '0;
            err_q      <= '0;
            ovr_q      <= 1'b0;
        end else begin
            rdy_prev_q <= iDATA_READY;
            key_in_q   <= key_in_d;
            cmd_q      <= cmd_d;
            key_q      <= key_d;
            valid_q    <= valid_d;
            last_key_q <= last_key_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign oCMD_VALID = valid_q;
    assign oCMD       = cmd_q;
    assign oKEY       = key_q;
    assign oOVERRUN   = ovr_q;
    assign oERR_CNT   = err_q;

endmodule

// File: tb/tb_ir_cmd_filter.sv
// tb_ir_cmd_filter: directed frames with a command scoreboard.
// Stimulus pushes expected commands; a monitor pops them as oCMD_VALID rises.

module tb_ir_cmd_filter;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iDATA_READY = 1'b0;
    logic [31:0] iDATA = '0;
    logic        iCMD_ACK = 1'b0;
    logic        oCMD_VALID;
    logic [1:0]  oCMD;
    logic [7:0]  oKEY;
    logic        oOVERRUN;
    logic [7:0]  oERR_CNT;

    ir_cmd_filter #(
        .HOLDOFF_CYC(100)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iDATA_READY(iDATA_READY),
        .iDATA(iDATA),
        .iCMD_ACK(iCMD_ACK),
        .oCMD_VALID(oCMD_VALID),
        .oCMD(oCMD),
        .oKEY(oKEY),
        .oOVERRUN(oOVERRUN),
        .oERR_CNT(oERR_CNT)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] key;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int vecs = 0;
    int miss = 0;
    int ovr_cnt = 0;
    int last_ev = 0;
    int o0 = 0;
    int exp_err = 0;
    bit auto_ack = 1'b0;
    bit force_ack = 1'b0;
    bit chk_clear = 1'b0;
    bit v_prev = 1'b0;

    localparam logic [31:0] F_ARM    = 32'hED12_6B86;
    localparam logic [31:0] F_DISARM = 32'hE51A_6B86;
    localparam logic [31:0] F_PANIC  = 32'hE11E_6B86;
    localparam logic [31:0] F_BADKEY = 32'hAA55_6B86;
    localparam logic [31:0] F_BADCC  = 32'hED12_1234;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Call at a negedge. Event is sampled at the next posedge; a command,
    // if any, is visible two edges later.
    task automatic frame(input logic [31:0] d, input bit expect_cmd,
                         input logic [1:0] c, input int hold);
        exp_t e;
        iDATA = d;
        iDATA_READY = 1'b1;
        last_ev = cyc + 1;
        if (expect_cmd) begin
            e.cmd = c;
            e.key = d[23:16];
            e.t   = cyc + 2;
            exp_q.push_back(e);
        end
        repeat (hold) @(negedge iCLK);
        iDATA_READY = 1'b0;
        @(negedge iCLK);
    endtask

    // Space the next frame event d cycles after the previous one.
    task automatic gap(input int d);
        while (cyc < last_ev + d - 1) @(negedge iCLK);
    endtask

    // Monitor: scoreboard pop on rising valid, ack driver, clear check.
    always begin
        @(negedge iCLK);
        if (!iRST) begin
            if (chk_clear) begin
                check("ack_clears_valid", 32'(oCMD_VALID), 32'd0);
                check("ack_clears_cmd", 32'(oCMD), 32'd0);
            end
            if (oCMD_VALID && !v_prev) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    miss++;
                    $display("FAIL unexpected_cmd: got cmd %b key %h want none",
                             oCMD, oKEY);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cmd", 32'(oCMD), 32'(mon_e.cmd));
                    check("key", 32'(oKEY), 32'(mon_e.key));
                    check("latency", 32'(cyc), 32'(mon_e.t));
                end
            end
            if (oOVERRUN) ovr_cnt++;
        end
        v_prev = oCMD_VALID;
        #1;
        iCMD_ACK = (auto_ack && oCMD_VALID) || force_ack;
        chk_clear = iCMD_ACK && oCMD_VALID;
    end

    initial begin
        // Reset with a frame level already present
        iRST = 1'b1;
        iDATA = F_ARM;
        iDATA_READY = 1'b1;
        repeat (3) @(negedge iCLK);
        check("rst_valid", 32'(oCMD_VALID), 32'd0);
        check("rst_cmd", 32'(oCMD), 32'd0);
        check("rst_key", 32'(oKEY), 32'd0);
        check("rst_ovr", 32'(oOVERRUN), 32'd0);
        check("rst_err", 32'(oERR_CNT), 32'd0);
        iRST = 1'b0;
        repeat (20000) @(negedge iCLK);
        check("level_no_cmd", 32'(oCMD_VALID), 32'd0);
        iDATA_READY = 1'b0;
        @(negedge iCLK);
        auto_ack = 1'b1;
        frame(F_ARM, 1'b1, 2'b01, 4);

        // Custom code and key rejects
        gap(150);
`ifdef IR_CUSTOM_CHECK_EN
        frame(F_BADCC, 1'b0, 2'b00, 4);
        exp_err = 1;
`else
        frame(F_BADCC, 1'b1, 2'b01, 4);
        exp_err = 0;
`endif
        check("err_custom", 32'(oERR_CNT), 32'(exp_err));
        gap(150);
        frame(F_BADKEY, 1'b0, 2'b00, 4);
        exp_err++;
        check("err_badkey", 32'(oERR_CNT), 32'(exp_err));

        // Holdoff window (100 cycles): 50 and 80 inside, then 101 outside
        gap(150);
        frame(F_ARM, 1'b1, 2'b01, 4);
        gap(50);
        frame(F_ARM, 1'b0, 2'b00, 4);
        gap(80);
        frame(F_ARM, 1'b0, 2'b00, 4);
        gap(101);
        frame(F_ARM, 1'b1, 2'b01, 4);
        gap(20);
        frame(F_DISARM, 1'b1, 2'b10, 4);
        check("err_holdoff", 32'(oERR_CNT), 32'(exp_err));

        // Overrun while PANIC pending
        gap(150);
        auto_ack = 1'b0;
        frame(F_PANIC, 1'b1, 2'b11, 3);
        check("panic_valid", 32'(oCMD_VALID), 32'd1);
        o0 = ovr_cnt;
        gap(30);
        frame(F_DISARM, 1'b0, 2'b00, 3);
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_cmd_held", 32'(oCMD), 32'h3);
        check("ovr_key_held", 32'(oKEY), 32'h1E);
        check("ovr_valid_held", 32'(oCMD_VALID), 32'd1);
        force_ack = 1'b1;
        @(negedge iCLK);
        force_ack = 1'b0;
        @(negedge iCLK);
        check("ack_valid_low", 32'(oCMD_VALID), 32'd0);

        // Reset while ISSUE
        gap(30);
        frame(F_DISARM, 1'b1, 2'b10, 3);
        check("pre_rst_valid", 32'(oCMD_VALID), 32'd1);
        #2;
        iRST = 1'b1;
        #1;
        check("arst_valid", 32'(oCMD_VALID), 32'd0);
        check("arst_cmd", 32'(oCMD), 32'd0);
        check("arst_key", 32'(oKEY), 32'd0);
        check("arst_err", 32'(oERR_CNT), 32'd0);
        check("arst_ovr", 32'(oOVERRUN), 32'd0);
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b0;
        auto_ack = 1'b1;
        repeat (10) @(negedge iCLK);
        frame(F_DISARM, 1'b1, 2'b10, 3);

        // Error counter saturation
        gap(150);
        for (int i = 0; i < 300; i++) begin
            frame(F_BADKEY, 1'b0, 2'b00, 1);
            if (i == 99) check("err_100", 32'(oERR_CNT), 32'd100);
        end
        check("err_sat", 32'(oERR_CNT), 32'd255);

        repeat (20) @(negedge iCLK);
        vecs++;
        if (exp_q.size() != 0) begin
            miss++;
            $display("FAIL missing_cmd: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
